// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, read-return tags
// and the {CEN, WEN, OEN} strobe patterns of the memory macro.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_NORM  = 2'd0,
        ST_FORCE = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_DMA  = 2'd2
    } tag_t;

    // {CEN, WEN, OEN}, all active-low
    localparam logic [2:0] MEM_IDLE  = 3'b111;
    localparam logic [2:0] MEM_WRITE = 3'b001;
    localparam logic [2:0] MEM_READ  = 3'b010;

endpackage

// File: rtl/dmem_port_mux.sv
// Steers the granted requester onto the memory macro pins; with no grant the
// pins go idle and address/data are held at zero.
module dmem_port_mux
    import dmem_pkg::*;
#(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          cpu_gnt,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dma_gnt,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [DW-1:0] Data2Mem
);

    logic [2:0] strobe_next;

    // The arbiter never raises both grants, so the CPU-first order is only a tie-break.
    always_comb begin
        strobe_next = MEM_IDLE;
        A           = '0;
        Data2Mem    = '0;
        if (cpu_gnt) begin
            strobe_next = cpu_we ? MEM_WRITE : MEM_READ;
            A           = cpu_addr;
            Data2Mem    = cpu_wdata;
        end else if (dma_gnt) begin
            strobe_next = dma_we ? MEM_WRITE : MEM_READ;
            A           = dma_addr;
            Data2Mem    = dma_wdata;
        end
    end

    assign {CEN, WEN, OEN} = strobe_next;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one 1-cycle-latency data-memory port between the CPU (priority) and a
// DMA/debug loader, with starvation-forced DMA slots and locked DMA bursts.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8,
    parameter int AW         = 7,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [DW-1:0] Data2Mem,
    input  logic [DW-1:0] ReadDataMem
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

    state_t     state_reg, state_next;
    logic [3:0] wait_reg, wait_next;
    logic [3:0] beat_reg, beat_next;
    tag_t       tag_reg, tag_next;

    // Grants depend only on the state and the live requests.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_NORM: begin
                    cpu_gnt = cpu_req;
                    dma_gnt = dma_req & ~cpu_req;
                end
                ST_FORCE: begin
                    dma_gnt = dma_req;
                    cpu_gnt = cpu_req & ~dma_req;
                end
                ST_BURST: dma_gnt = dma_req;
                default: ;
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        wait_next  = 4'd0;
        state_next = state_reg;
        beat_next  = beat_reg;
        if (dma_req && !dma_gnt)
            wait_next = (wait_reg == 4'hF) ? 4'hF : wait_reg + 4'd1;

        case (state_reg)
            ST_NORM, ST_FORCE: begin
                // A forced slot lasts one cycle; a locked grant from either state opens a burst.
                state_next = ST_NORM;
                if (dma_gnt && dma_lock && (BURST_MAX > 1)) begin
                    state_next = ST_BURST;
                    beat_next  = 4'd1;
                end else if (state_reg == ST_NORM && wait_next == STARVE_LIM) begin
                    state_next = ST_FORCE;
                end
            end
            ST_BURST: begin
                if (dma_gnt)
                    beat_next = beat_reg + 4'd1;
                if (!dma_req || !dma_lock || beat_next >= BURST_LIM) begin
                    state_next = ST_NORM;
                    beat_next  = 4'd0;
                end
            end
            default: begin
                state_next = ST_NORM;
                beat_next  = 4'd0;
            end
        endcase

        tag_next = TAG_NONE;
        if (cpu_gnt && !cpu_we)
            tag_next = TAG_CPU;
        else if (dma_gnt && !dma_we)
            tag_next = TAG_DMA;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_NORM;
            wait_reg  <= 4'd0;
            beat_reg  <= 4'd0;
            tag_reg   <= TAG_NONE;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            beat_reg  <= beat_next;
            tag_reg   <= tag_next;
        end
    end

    // Gating with rst_n keeps a read issued just before reset from returning.
    assign cpu_rvalid = rst_n && (tag_reg == TAG_CPU);
    assign dma_rvalid = rst_n && (tag_reg == TAG_DMA);
    assign cpu_rdata  = cpu_rvalid ? ReadDataMem : '0;
    assign dma_rdata  = dma_rvalid ? ReadDataMem : '0;

    dmem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_port_mux (
        .cpu_gnt   (cpu_gnt),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dma_gnt   (dma_gnt),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .CEN       (CEN),
        .WEN       (WEN),
        .OEN       (OEN),
        .A         (A),
        .Data2Mem  (Data2Mem)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a behavioural
// arbitration model and a behavioural 128x32 memory with 1-cycle read latency.
module tb_dmem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int BURST_MAX  = 8;
    localparam int AW         = 7;
    localparam int DW         = 32;

    logic          clk;
    logic          rst_n;
    logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [AW-1:0] cpu_addr, dma_addr, A;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, Data2Mem, ReadDataMem;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic          CEN, WEN, OEN;

    dmem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .BURST_MAX  (BURST_MAX),
        .AW         (AW),
        .DW         (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_lock    (dma_lock),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural memory (driven by DUT pins) and the bench's expected contents.
    logic [DW-1:0] env_mem [128];
    logic [DW-1:0] shadow  [128];

    // Abstract arbitration model
    bit            owed;       // DMA is owed a forced slot this cycle
    bit            bursting;
    int            beats;
    int            waited;
    int            rtag;       // 0 none, 1 cpu, 2 dma
    logic [DW-1:0] rexp;

    logic          obs_cg, obs_dg, obs_stall, obs_crv, obs_drv;
    logic [DW-1:0] obs_crd, obs_drd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic cr, input logic cw,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic dr, input logic dw, input logic dl,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd);
        logic          eg_c, eg_d;
        logic [2:0]    e_str;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        logic          p_cen, p_wen, p_oen;
        logic [AW-1:0] p_a;
        logic [DW-1:0] p_d;
        logic          e_crv, e_drv;
        int            w_new;

        @(negedge clk);
        rst_n = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
        #1;

        eg_c = 1'b0;
        eg_d = 1'b0;
        if (r) begin
            if (bursting)  eg_d = dr;
            else if (owed) begin eg_d = dr; eg_c = cr && !dr; end
            else           begin eg_c = cr; eg_d = dr && !cr; end
        end
        e_str = 3'b111; e_a = '0; e_d = '0;
        if (eg_c)      begin e_str = cw ? 3'b001 : 3'b010; e_a = ca; e_d = cd; end
        else if (eg_d) begin e_str = dw ? 3'b001 : 3'b010; e_a = da; e_d = dd; end
        e_crv = r && (rtag == 1);
        e_drv = r && (rtag == 2);

        chk("cpu_gnt",   32'(cpu_gnt),   32'(eg_c));
        chk("dma_gnt",   32'(dma_gnt),   32'(eg_d));
        chk("cpu_stall", 32'(cpu_stall), 32'(cr && !eg_c));
        chk("strobes",   32'({CEN, WEN, OEN}), 32'(e_str));
        chk("addr",      32'(A),         32'(e_a));
        chk("wdata",     Data2Mem,       e_d);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(e_drv));
        chk("cpu_rdata", cpu_rdata, e_crv ? rexp : '0);
        chk("dma_rdata", dma_rdata, e_drv ? rexp : '0);

        obs_cg = cpu_gnt; obs_dg = dma_gnt; obs_stall = cpu_stall;
        obs_crv = cpu_rvalid; obs_drv = dma_rvalid; obs_crd = cpu_rdata; obs_drd = dma_rdata;
        p_cen = CEN; p_wen = WEN; p_oen = OEN; p_a = A; p_d = Data2Mem;

        @(posedge clk);
        if (!p_cen && !p_wen)      env_mem[p_a] = p_d;
        else if (!p_cen && !p_oen) ReadDataMem  = env_mem[p_a];

        if (!r) begin
            owed = 0; bursting = 0; beats = 0; waited = 0; rtag = 0;
        end else begin
            w_new = (dr && !eg_d) ? ((waited < 15) ? waited + 1 : 15) : 0;
            rtag = 0;
            if (eg_c && !cw)      begin rtag = 1; rexp = shadow[ca]; end
            else if (eg_d && !dw) begin rtag = 2; rexp = shadow[da]; end
            if (eg_c && cw) shadow[ca] = cd;
            if (eg_d && dw) shadow[da] = dd;
            if (bursting) begin
                if (eg_d) beats++;
                if (!dr || !dl || beats >= BURST_MAX) bursting = 0;
                owed = 0;
            end else if (eg_d && dl) begin
                bursting = 1; beats = 1; owed = 0;
            end else begin
                owed = !owed && (w_new == STARVE_MAX);
            end
            waited = w_new;
        end
    endtask

    task automatic idle();
        cycle(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        logic [AW-1:0] daddr;
        rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
        ReadDataMem = '0;
        owed = 0; bursting = 0; beats = 0; waited = 0; rtag = 0; rexp = '0;
        for (int a = 0; a < 128; a++) begin
            shadow[a]  = $urandom;
            env_mem[a] = shadow[a];
        end
        shadow[5]  = 32'hDEADBEEF;
        env_mem[5] = 32'hDEADBEEF;

        // Reset with both ports requesting
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 7'h03, '0, 1, 0, 0, 7'h04, '0);
            chk("rst_stall", 32'(obs_stall), 32'd1);
            chk("rst_no_rvalid", 32'(obs_crv | obs_drv), 32'd0);
        end
        cycle(1, 1, 0, 7'h03, '0, 0, 0, 0, '0, '0);
        chk("post_rst_cpu_gnt", 32'(obs_cg), 32'd1);

        // CPU read of address 5
        cycle(1, 1, 0, 7'h05, '0, 0, 0, 0, '0, '0);
        cycle(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        chk("cpu_read_rvalid", 32'(obs_crv), 32'd1);
        chk("cpu_read_data", obs_crd, 32'hDEADBEEF);
        chk("cpu_read_dma_rvalid", 32'(obs_drv), 32'd0);

        // Starvation: DMA gets every 5th slot
        idle();
        for (int i = 1; i <= 10; i++) begin
            cycle(1, 1, 0, 7'($urandom), '0, 1, 0, 0, 7'($urandom), '0);
            chk($sformatf("starve_dgnt_%0d", i), 32'(obs_dg), 32'(i % 5 == 0));
            chk($sformatf("starve_stall_%0d", i), 32'(obs_stall), 32'(i % 5 == 0));
        end

        // Locked burst writes to 0..9 against a busy CPU
        idle();
        daddr = '0;
        for (int i = 1; i <= 13; i++) begin
            cycle(1, 1, 0, 7'h40, '0, (daddr < 10), 1, 1, daddr, $urandom);
            if (obs_dg) daddr++;
            chk($sformatf("burst_dgnt_%0d", i), 32'(obs_dg), 32'(i >= 5 && i <= 12));
        end
        chk("burst_then_cpu", 32'(obs_cg), 32'd1);

        // Burst abort by dropping dma_lock after beat 3
        idle();
        for (int i = 1; i <= 9; i++) begin
            cycle(1, 1, 0, 7'h41, '0, 1, 0, (i < 8), 7'(16 + i), '0);
            if (i == 9) begin
                chk("abort_cpu_gnt", 32'(obs_cg), 32'd1);
                chk("abort_dma_gnt", 32'(obs_dg), 32'd0);
            end
        end

        // Reset at beat 2 of a locked read burst
        idle();
        cycle(1, 0, 0, '0, '0, 1, 0, 1, 7'h20, '0);
        cycle(1, 0, 0, '0, '0, 1, 0, 1, 7'h21, '0);
        cycle(0, 0, 0, '0, '0, 1, 0, 1, 7'h22, '0);
        chk("mid_burst_rst_gnt", 32'(obs_dg), 32'd0);
        chk("mid_burst_rst_rvalid", 32'(obs_drv), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
            chk("after_rst_dgnt", 32'(obs_dg), 32'd0);
            chk("after_rst_rvalid", 32'(obs_drv), 32'd0);
        end

        // Alternating CPU / forced DMA reads
        idle();
        for (int i = 1; i <= 6; i++) begin
            cycle(1, 1, 0, 7'h01, '0, 1, 0, 0, 7'h02, '0);
            if (i == 5) begin
                chk("alt_dma_gnt", 32'(obs_dg), 32'd1);
                chk("alt_cpu_rvalid", 32'(obs_crv), 32'd1);
                chk("alt_cpu_rdata", obs_crd, shadow[1]);
            end
            if (i == 6) begin
                chk("alt_dma_rvalid", 32'(obs_drv), 32'd1);
                chk("alt_dma_rdata", obs_drd, shadow[2]);
            end
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 60) != 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 7'($urandom), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                  7'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
